// File: rtl/input_debouncer.sv
// input_debouncer: synchronise and debounce raw input A into A_level with rise/fall strobes; A_toggle register only when TOGGLE_OUT_EN is defined
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  output logic A_level,
  output logic A_rise,
  output logic A_fall,
  output logic A_toggle
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {STABLE, COUNT} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic s, diff, accept;
  assign s = sync[SYNC_STAGES-1];
  assign diff = s != A_level;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {SYNC_STAGES{INIT_LEVEL}};
    else sync <= {sync[SYNC_STAGES-2:0], A};
  always_comb begin
    accept = diff && (state == STABLE ? DEBOUNCE_CYCLES == 1 : cnt >= LAST);
    state_nx = diff && !accept ? COUNT : STABLE;
    cnt_nx = state_nx == STABLE ? '0 : state == COUNT ? cnt + 1'b1 : CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= STABLE;
      cnt     <= '0;
      A_level <= INIT_LEVEL;
      A_rise  <= 1'b0;
      A_fall  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      A_level <= accept ? s : A_level;
      A_rise  <= accept & s;
      A_fall  <= accept & ~s;
    end
`ifdef TOGGLE_OUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) A_toggle <= 1'b0;
    else A_toggle <= A_toggle ^ A_rise;
`else
  assign A_toggle = 1'b0;
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: randomized and directed checks of input_debouncer against a run-length reference model
module tb_input_debouncer;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam bit INIT = 1'b0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A = 1'b0;
  logic A_level, A_rise, A_fall, A_toggle;
  int errs = 0;
  int checks = 0;
  bit q[$];
  bit m_lvl, m_rise, m_fall, m_tog;
  int streak;

  input_debouncer #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .INIT_LEVEL(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .A(A),
    .A_level(A_level), .A_rise(A_rise), .A_fall(A_fall), .A_toggle(A_toggle)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] expv();
`ifdef TOGGLE_OUT_EN
    return {m_lvl, m_rise, m_fall, m_tog};
`else
    return {m_lvl, m_rise, m_fall, 1'b0};
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    repeat (SS) q.push_back(INIT);
    m_lvl = INIT; m_rise = 0; m_fall = 0; m_tog = 0; streak = 0;
  endtask

  // Drive A, take one rising edge, advance the model, settle #1 past the edge.
  task automatic cycle(input bit a);
    bit s;
    A = a;
    @(posedge clk);
    s = q.pop_front();
    q.push_back(a);
    streak = (s != m_lvl) ? streak + 1 : 0;
    m_rise = 0; m_fall = 0;
    if (streak >= DC) begin
      m_rise = s; m_fall = !s; m_lvl = s; streak = 0; m_tog ^= s;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; A = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({A_level, A_rise, A_fall, A_toggle} !== {INIT, 3'b000}) begin
      errs++; $display("FAIL reset_values: got %b want %b", {A_level, A_rise, A_fall, A_toggle}, {INIT, 3'b000});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle(0);
      checks++;
      if ({A_level, A_rise, A_fall} !== 3'b000) begin
        errs++; $display("FAIL reset_hold edge %0d: got %b want 000", i, {A_level, A_rise, A_fall});
      end
    end
  endtask

  task automatic test_clean_step();
    int at_r = -1;
    int at_f = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(1);
      checks++;
      if ({A_level, A_rise, A_fall, A_toggle} !== expv()) begin
        errs++; $display("FAIL clean_rise edge %0d: got %b want %b", i, {A_level, A_rise, A_fall, A_toggle}, expv());
      end
      if (A_rise && at_r < 0) at_r = i;
    end
    checks++;
    if (at_r != SS + DC) begin
      errs++; $display("FAIL clean_rise_latency: got %0d want %0d", at_r, SS + DC);
    end
    for (int i = 1; i <= 10; i++) begin
      cycle(0);
      checks++;
      if ({A_level, A_rise, A_fall, A_toggle} !== expv()) begin
        errs++; $display("FAIL clean_fall edge %0d: got %b want %b", i, {A_level, A_rise, A_fall, A_toggle}, expv());
      end
      if (A_fall && at_f < 0) at_f = i;
    end
    checks++;
    if (at_f != SS + DC) begin
      errs++; $display("FAIL clean_fall_latency: got %0d want %0d", at_f, SS + DC);
    end
  endtask

  task automatic test_glitch();
    int at = -1;
    for (int i = 1; i <= 9; i++) begin
      cycle(i <= 3);
      checks++;
      if ({A_level, A_rise, A_fall} !== 3'b000) begin
        errs++; $display("FAIL glitch edge %0d: got %b want 000", i, {A_level, A_rise, A_fall});
      end
    end
    for (int i = 1; i <= 10; i++) begin
      cycle(1);
      checks++;
      if ({A_level, A_rise, A_fall, A_toggle} !== expv()) begin
        errs++; $display("FAIL glitch_then_hold edge %0d: got %b want %b", i, {A_level, A_rise, A_fall, A_toggle}, expv());
      end
      if (A_rise && at < 0) at = i;
    end
    checks++;
    if (at != SS + DC) begin
      errs++; $display("FAIL glitch_then_hold_latency: got %0d want %0d", at, SS + DC);
    end
    repeat (10) cycle(0);
  endtask

  task automatic test_bounce();
    bit pat[15] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int rises = 0;
    int falls = 0;
    int at = -1;
    for (int i = 0; i < 15; i++) begin
      cycle(pat[i]);
      checks++;
      if ({A_level, A_rise, A_fall, A_toggle} !== expv()) begin
        errs++; $display("FAIL bounce edge %0d: got %b want %b", i + 1, {A_level, A_rise, A_fall, A_toggle}, expv());
      end
      rises += A_rise;
      falls += A_fall;
      if (A_rise && at < 0) at = i + 1;
    end
    checks++;
    if (rises != 1 || falls != 0 || at != 9 + SS) begin
      errs++; $display("FAIL bounce_summary: got rises=%0d falls=%0d at=%0d want 1 0 %0d", rises, falls, at, 9 + SS);
    end
    repeat (10) cycle(0);
  endtask

  task automatic test_reset_mid_count();
    int at = -1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1);
      checks++;
      if ({A_level, A_rise, A_fall} !== 3'b000) begin
        errs++; $display("FAIL pre_reset edge %0d: got %b want 000", i, {A_level, A_rise, A_fall});
      end
    end
    #1 rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({A_level, A_rise, A_fall, A_toggle} !== 4'b0000) begin
        errs++; $display("FAIL in_reset step %0d: got %b want 0000", i, {A_level, A_rise, A_fall, A_toggle});
      end
      @(posedge clk);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle(1);
      checks++;
      if ({A_level, A_rise, A_fall, A_toggle} !== expv()) begin
        errs++; $display("FAIL post_reset edge %0d: got %b want %b", i, {A_level, A_rise, A_fall, A_toggle}, expv());
      end
      if (A_rise && at < 0) at = i;
    end
    checks++;
    if (at != SS + DC) begin
      errs++; $display("FAIL post_reset_latency: got %0d want %0d", at, SS + DC);
    end
    repeat (10) cycle(0);
  endtask

  task automatic test_toggle();
    bit want;
    A = 1'b0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      repeat (9) cycle(1);
`ifdef TOGGLE_OUT_EN
      want = (p % 2) == 0;
`else
      want = 1'b0;
`endif
      checks++;
      if (A_toggle !== want) begin
        errs++; $display("FAIL toggle press %0d: got %b want %b", p, A_toggle, want);
      end
      repeat (9) cycle(0);
      checks++;
      if ({A_level, A_toggle} !== {1'b0, want}) begin
        errs++; $display("FAIL toggle release %0d: got %b want %b", p, {A_level, A_toggle}, {1'b0, want});
      end
    end
  endtask

  task automatic test_random();
    bit v;
    int len;
    for (int r = 0; r < 80; r++) begin
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        cycle(v);
        checks++;
        if ({A_level, A_rise, A_fall, A_toggle} !== expv()) begin
          errs++; $display("FAIL random run %0d: got %b want %b", r, {A_level, A_rise, A_fall, A_toggle}, expv());
        end
        checks++;
        if (A_rise && A_fall) begin
          errs++; $display("FAIL random_both_strobes run %0d: got 11 want not both", r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_reset_mid_count();
    test_toggle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
